// File: rtl/iob_sipo_frame_ctrl.sv
// Frame controller for an external serial-in/parallel-out shift register.
// Accepts serial bits over valid/ready and drives the register's shift enable.
// Counts a programmable word length, then captures and masks the parallel word
// into a one-entry output buffer with a valid/ready handshake.
module iob_sipo_frame_ctrl #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_cont,
  input  logic              s_valid,
  input  logic              s_bit,
  output logic              s_ready,
  output logic              sipo_en,
  output logic              sipo_s_in,
  input  logic [DATA_W-1:0] sipo_p_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE} state_t;

  state_t              r_state, w_state_nxt;
  logic [LEN_W-1:0]    r_bit_cnt;
  logic [LEN_W-1:0]    r_len_q;
  logic                r_cont_q;
  logic                r_m_valid;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_overflow;

  logic                w_accept;
  logic                w_last;
  logic                w_buf_free;
  logic [LEN_W-1:0]    w_len_clamp;
  logic [DATA_W-1:0]   w_mask;

  assign s_ready   = (r_state == SHIFT);
  assign sipo_en   = s_valid & s_ready;
  assign sipo_s_in = s_bit;
  assign busy      = (r_state != IDLE);
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign overflow  = r_overflow;

  assign w_accept    = s_valid & (r_state == SHIFT);
  assign w_last      = (r_bit_cnt == r_len_q - LEN_W'(1));
  assign w_buf_free  = !r_m_valid || m_ready;
  // Zero or oversized lengths fall back to a full-width word.
  assign w_len_clamp = ((cfg_len == '0) || (cfg_len > LEN_MAX)) ? LEN_MAX : cfg_len;

  // Keep only the low len_q bits; older SIPO contents above them are stale.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DATA_W; i++)
      w_mask[i] = (int'(r_len_q) > i);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a start while shifting restarts in place.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (!start && w_accept && w_last) w_state_nxt = CAPTURE;
      CAPTURE: w_state_nxt = r_cont_q ? SHIFT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame config, bit counter, output buffer and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_len_q    <= LEN_MAX;
      r_cont_q   <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Consumer handshake and clear first; a capture below overrides them.
      if (r_m_valid && m_ready) r_m_valid  <= 1'b0;
      if (overflow_clr)         r_overflow <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len_q   <= w_len_clamp;
            r_cont_q  <= cfg_cont;
            r_bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (start) begin
            r_len_q   <= w_len_clamp;
            r_cont_q  <= cfg_cont;
            r_bit_cnt <= '0;
          end else if (w_accept) begin
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + LEN_W'(1);
          end
        end
        CAPTURE: begin
          r_bit_cnt <= '0;
          if (w_buf_free) begin
            r_m_data  <= sipo_p_out & w_mask;
            r_m_valid <= 1'b1;
          end else begin
            r_overflow <= 1'b1;
          end
        end
        default: r_bit_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_sipo_frame_ctrl.sv
// Bench for iob_sipo_frame_ctrl (DATA_W=8, LEN_W=4): models the external SIPO
// register, runs a word-level reference model and compares every cycle,
// plus literal expectations for each directed scenario.
module tb_iob_sipo_frame_ctrl;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst, start, cfg_cont, s_valid, s_bit, m_ready, overflow_clr;
  logic [LW-1:0] cfg_len;
  logic          s_ready, sipo_en, sipo_s_in, m_valid, busy, overflow;
  logic [DW-1:0] sipo_p_out, m_data;

  // External SIPO register, with a preload hook for stale-content tests.
  logic          sipo_load;
  logic [DW-1:0] sipo_load_val;
  logic [DW-1:0] sipo_q;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iob_sipo_frame_ctrl #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_cont(cfg_cont),
    .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready), .sipo_en(sipo_en),
    .sipo_s_in(sipo_s_in), .sipo_p_out(sipo_p_out), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .busy(busy), .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  assign sipo_p_out = sipo_q;

  always @(posedge clk) begin
    if (sipo_load)    sipo_q <= sipo_load_val;
    else if (sipo_en) sipo_q <= {sipo_q[DW-2:0], sipo_s_in};
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame phase, bits collected so far, buffered word.
  int mph;      // 0 idle, 1 collecting bits, 2 word complete (capture cycle)
  int mlen, mcont, mcnt, macc, mvalid, mdata, movf;
  bit mdl_ok = 1'b0;

  function automatic int clamp_len(input int l);
    return (l == 0 || l > DW) ? DW : l;
  endfunction

  always @(posedge clk) begin
    int nv, no;
    if (rst) begin
      mph = 0; mlen = DW; mcont = 0; mcnt = 0; macc = 0;
      mvalid = 0; mdata = 0; movf = 0; mdl_ok = 1'b1;
    end else if (mdl_ok) begin
      nv = (mvalid && m_ready) ? 0 : mvalid;
      no = overflow_clr ? 0 : movf;
      case (mph)
        0: if (start) begin
             mph = 1; mlen = clamp_len(int'(cfg_len)); mcont = int'(cfg_cont);
             mcnt = 0; macc = 0;
           end
        1: if (start) begin
             mlen = clamp_len(int'(cfg_len)); mcont = int'(cfg_cont);
             mcnt = 0; macc = 0;
           end else if (s_valid) begin
             macc = macc * 2 + int'(s_bit);
             mcnt++;
             if (mcnt == mlen) mph = 2;
           end
        default: begin
          if (!mvalid || m_ready) begin
            mdata = macc % (1 << mlen);
            nv = 1;
          end else begin
            no = 1;
          end
          mph = mcont ? 1 : 0;
          mcnt = 0; macc = 0;
        end
      endcase
      mvalid = nv;
      movf = no;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mdl_ok && !rst) begin
      chk("busy",      int'(busy),      int'(mph != 0));
      chk("s_ready",   int'(s_ready),   int'(mph == 1));
      chk("sipo_en",   int'(sipo_en),   int'(s_valid && mph == 1));
      chk("sipo_s_in", int'(sipo_s_in), int'(s_bit));
      chk("m_valid",   int'(m_valid),   mvalid);
      chk("m_data",    int'(m_data),    mdata);
      chk("overflow",  int'(overflow),  movf);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input bit cont);
    cfg_len = LW'(len); cfg_cont = cont; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one bit and hold it until the controller accepts it.
  task automatic send_bit(input bit b);
    int n = 0;
    s_valid = 1'b1; s_bit = b;
    while (!s_ready && n < 20) begin step(); n++; end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic send_word(input int w, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic wait_mvalid(input string nm);
    int n = 0;
    while (!m_valid && n < 30) begin step(); n++; end
    if (!m_valid) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 0; cfg_len = '0; cfg_cont = 0; s_valid = 0; s_bit = 0;
    m_ready = 0; overflow_clr = 0; sipo_load = 0; sipo_load_val = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_mvalid", int'(m_valid), 0);
    chk("rst_mdata", int'(m_data), 0);
    chk("rst_sready", int'(s_ready), 0);

    // 1) Full-length word, latency t+2, single-cycle valid, back to idle.
    m_ready = 1'b1;
    do_start(8, 1'b0);
    send_word(8'hB2, 8);
    chk("t1_capture_not_yet", int'(m_valid), 0);
    step();
    chk("t1_mvalid_t2", int'(m_valid), 1);
    chk("t1_mdata", int'(m_data), 8'hB2);
    step();
    chk("t1_mvalid_drop", int'(m_valid), 0);
    chk("t1_idle", int'(busy), 0);

    // 2) Stale SIPO contents above len are masked.
    sipo_load = 1'b1; sipo_load_val = 8'hFF; step(); sipo_load = 1'b0;
    do_start(3, 1'b0);
    send_word(3'b110, 3);
    wait_mvalid("t2");
    chk("t2_mdata", int'(m_data), 8'h06);
    step();

    // 3) Continuous mode with a stalled consumer: second word dropped.
    m_ready = 1'b0;
    do_start(4, 1'b1);
    send_word(4'hA, 4);
    send_word(4'h6, 4);
    step(); step();
    chk("t3_mdata_held", int'(m_data), 8'h0A);
    chk("t3_mvalid", int'(m_valid), 1);
    chk("t3_overflow", int'(overflow), 1);
    overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
    chk("t3_overflow_clr", int'(overflow), 0);
    rst = 1'b1; step(); rst = 1'b0;

    // 4) Restart mid-frame; the bit offered alongside start is discarded.
    m_ready = 1'b1;
    do_start(8, 1'b0);
    send_word(5'b10111, 5);
    cfg_len = 4'd8; start = 1'b1; s_valid = 1'b1; s_bit = 1'b1;
    step();
    start = 1'b0; s_valid = 1'b0;
    send_word(8'hC3, 8);
    wait_mvalid("t4");
    chk("t4_mdata", int'(m_data), 8'hC3);
    chk("t4_overflow", int'(overflow), 0);
    step();

    // 5) Length 0 and length 12 both mean a full 8-bit word.
    do_start(0, 1'b0);
    send_word(7'h2D, 7);
    chk("t5a_no_word_at_7", int'(m_valid), 0);
    chk("t5a_still_busy", int'(busy), 1);
    send_bit(1'b0);
    wait_mvalid("t5a");
    chk("t5a_mdata", int'(m_data), 8'h5A);
    step();
    do_start(12, 1'b0);
    send_word(7'h40, 7);
    chk("t5b_no_word_at_7", int'(m_valid), 0);
    send_bit(1'b1);
    wait_mvalid("t5b");
    chk("t5b_mdata", int'(m_data), 8'h81);
    step();

    // 6) Reset mid-frame drops partial bits and the buffered word.
    m_ready = 1'b0;
    do_start(2, 1'b0);
    send_word(2'b11, 2);
    wait_mvalid("t6_pre");
    do_start(8, 1'b0);
    send_word(4'hF, 4);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_mvalid", int'(m_valid), 0);
    chk("t6_mdata", int'(m_data), 0);
    chk("t6_sready", int'(s_ready), 0);
    chk("t6_overflow", int'(overflow), 0);
    m_ready = 1'b1;
    do_start(8, 1'b0);
    send_word(8'h3C, 8);
    wait_mvalid("t6");
    chk("t6_mdata_new", int'(m_data), 8'h3C);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
